// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the memory-access stage.
//   mem_state_t     : access FSM state (IDLE / BUSY)
//   RESULT_SRC_*    : encodings of the writeback result select
package mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    localparam logic [1:0] RESULT_SRC_ALU = 2'b00;
    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
    localparam logic [1:0] RESULT_SRC_PC  = 2'b10;

endpackage

// File: rtl/mem_stage_data_ram.sv
// data_ram: word-addressed data RAM, no reset.
//   clk   : write clock
//   we    : write enable, RAM[addr] <= wdata on posedge
//   addr  : word index (RAM_AW bits)
//   wdata : write data
//   rdata : combinational read of RAM[addr]
module data_ram
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RAM_AW     = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [RAM_AW-1:0]     addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(1 << RAM_AW)-1];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage plus MEM/WB pipeline register.
//   clk, rst                 : clock, synchronous active-high reset
//   RegWriteM .. PC_PlusM    : EX/MEM register outputs (M-stage instruction)
//   StallM                   : combinational freeze request for upstream stages
//   RegWriteW .. PC_PlusW    : registered MEM/WB outputs to writeback
// Loads and stores take MEM_LATENCY cycles (1..15); StallM is high for the
// first MEM_LATENCY-1 of them while W receives bubbles.
module mem_stage
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int RAM_AW      = 10,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWriteM,
    input  logic [1:0]            ResultSrcM,
    input  logic                  MemWriteM,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    input  logic [4:0]            RdM,
    input  logic [DATA_WIDTH-1:0] PC_PlusM,
    output logic                  StallM,
    output logic                  RegWriteW,
    output logic [1:0]            ResultSrcW,
    output logic [DATA_WIDTH-1:0] ALUResultW,
    output logic [DATA_WIDTH-1:0] ReadDataW,
    output logic [4:0]            RdW,
    output logic [DATA_WIDTH-1:0] PC_PlusW
);

    localparam logic [3:0] CNT_INIT = 4'((MEM_LATENCY > 1) ? (MEM_LATENCY - 2) : 0);

    mem_state_t            state;
    logic [3:0]            cnt;
    logic                  memop;
    logic                  stall_raw;
    logic                  ram_we;
    logic [RAM_AW-1:0]     idx;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  unused_addr_bits;

    assign memop = MemWriteM | (ResultSrcM == RESULT_SRC_MEM);
    assign idx   = ALUResultM[RAM_AW+1:2];

    // Byte offset and bits above the RAM index are deliberately ignored.
    assign unused_addr_bits = ^{ALUResultM[DATA_WIDTH-1:RAM_AW+2], ALUResultM[1:0]};

    // Holding (stall_raw) and completing are mutually exclusive: whenever the
    // stage does not hold, the M instruction retires into W at the next edge,
    // and a memop among them completes its access at that same edge.
    always_comb begin
        stall_raw = 1'b0;
        case (state)
            IDLE:    stall_raw = memop && (MEM_LATENCY > 1);
            BUSY:    stall_raw = (cnt != 4'd0);
            default: stall_raw = 1'b0;
        endcase
    end

    assign StallM = stall_raw & ~rst;
    assign ram_we = ~rst & ~stall_raw & MemWriteM;

    data_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .RAM_AW     (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (idx),
        .wdata (WriteDataM),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= '0;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            RdW        <= '0;
            PC_PlusW   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (memop && (MEM_LATENCY > 1)) begin
                        state <= BUSY;
                        cnt   <= CNT_INIT;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (stall_raw) begin
                RegWriteW  <= 1'b0;
                ResultSrcW <= '0;
                ALUResultW <= '0;
                ReadDataW  <= '0;
                RdW        <= '0;
                PC_PlusW   <= '0;
            end else begin
                RegWriteW  <= RegWriteM;
                ResultSrcW <= ResultSrcM;
                ALUResultW <= ALUResultM;
                ReadDataW  <= ram_rdata;
                RdW        <= RdM;
                PC_PlusW   <= PC_PlusM;
            end
        end
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage plus MEM/WB pipeline register. It consumes the EX/MEM register outputs and services loads and stores against an internal word-addressed data RAM.
- Hides a configurable multi-cycle RAM latency by asserting StallM, which freezes PC, IF/ID, ID/EX and EX/MEM.
- Delivers Rd, control, ALU result and load data to writeback.

Parameters:
- DATA_WIDTH, 32: datapath width.
- RAM_AW, 10: log2 of RAM depth in words; word index is ALUResultM[RAM_AW+1:2].
- MEM_LATENCY, 2: cycles per load/store access; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- RegWriteM  in  1  register-file write enable of the M-stage instruction.
- ResultSrcM  in  2  result select; 2'b01 means load.
- MemWriteM  in  1  store request.
- ALUResultM  in  DATA_WIDTH  byte address, or ALU result for non-memory ops.
- WriteDataM  in  DATA_WIDTH  store data.
- RdM  in  5  destination register.
- PC_PlusM  in  DATA_WIDTH  PC+4 for jal/jalr writeback.
- StallM  out  1  pipeline freeze request (combinational).
- RegWriteW  out  1  registered.
- ResultSrcW  out  2  registered.
- ALUResultW  out  DATA_WIDTH  registered.
- ReadDataW  out  DATA_WIDTH  registered load data.
- RdW  out  5  registered.
- PC_PlusW  out  DATA_WIDTH  registered.

Behaviour:
- Memory op: memop = MemWriteM | (ResultSrcM == 2'b01). MemWriteM and load are never asserted together. ALUResultM[1:0] is ignored (word access only).
- Address bits above RAM_AW+1 are ignored, so addresses wrap modulo RAM depth.
- FSM states are IDLE and BUSY. Down-counter cnt is 4 bits.
- IDLE, no memop: W registers load all M inputs on the next edge. ReadDataW is set to the RAM word at the current index, which is don't-care but deterministic. No stall.
- IDLE, memop, MEM_LATENCY == 1: the access completes at this edge.
  - A store writes RAM[idx] <= WriteDataM.
  - A load sets ReadDataW <= RAM[idx].
  - W registers load normally. StallM = 0.
- IDLE, memop, MEM_LATENCY > 1: StallM = 1. Next edge: go to BUSY, cnt <= MEM_LATENCY-2, W registers load a bubble.
- BUSY: M inputs are held stable by the stall.
  - StallM = (cnt != 0).
  - cnt != 0: cnt decrements, W registers get a bubble.
  - cnt == 0: the access completes at this edge exactly as in the MEM_LATENCY == 1 case, and the FSM returns to IDLE.
- Net timing: a memop stays in M for exactly MEM_LATENCY cycles. StallM is high for the first MEM_LATENCY-1 of them.
- Bubble: RegWriteW = 0, ResultSrcW = 0, RdW = 0, other W data = 0. A bubble never writes the register file.
- Each store writes RAM exactly once, at its completion edge. A store immediately followed by a load to the same word returns the new data.
- Back-to-back memops: the second one enters IDLE handling the cycle after the first completes; there is no idle gap.
- Reset: next edge sets state IDLE, cnt 0, all W outputs 0. StallM is 0 while rst is high.
- Reset mid-access: the pending store is dropped (RAM not written) and the pending load is discarded.
- RAM contents are not reset.

Decomposition:
- mem_pkg holds:
  - the enum mem_state_t {IDLE, BUSY};
  - localparam RESULT_SRC_MEM = 2'b01;
  - localparam RESULT_SRC_ALU = 2'b00;
  - localparam RESULT_SRC_PC = 2'b10.
- Sub-module data_ram, parameters DATA_WIDTH and RAM_AW:
  - combinational read port;
  - synchronous write port with we, addr, wdata;
  - no reset.
- mem_stage holds the FSM, counter, stall logic and MEM/WB register.

Test Plan:
- MEM_LATENCY=2, store 0xDEADBEEF to 0x40, then load 0x40 with Rd=5 -> StallM high 1 cycle for each op. Load yields RegWriteW=1, RdW=5, ReadDataW=0xDEADBEEF, ResultSrcW=01.
- MEM_LATENCY=2, stream of ALU ops with ResultSrcM=00, RegWrite=1, Rd=1,2,3 -> no stall. RdW=1,2,3 on consecutive cycles, one cycle after each M.
- MEM_LATENCY=4, load from 0x1000 with RAM_AW=10 (wraps to word 0, preloaded 0x12345678) -> StallM high 3 cycles, then 0x12345678. Exactly 3 bubbles plus 1 valid W beat.
- MEM_LATENCY=3, rst asserted in the 2nd cycle of a store of 0xAAAA5555 to 0x8 -> all W outputs 0 next cycle, StallM=0. A subsequent load of 0x8 returns the old value, not 0xAAAA5555.
- MEM_LATENCY=1, store 0x1 to 0x0, load 0x0, store 0x2 to 0x0, load 0x0 back-to-back -> never stalls. Loads return 0x1, then 0x2.
- MEM_LATENCY=2, jal-type op (ResultSrcM=10, PC_PlusM=0x104, Rd=1) -> PC_PlusW=0x104, RegWriteW=1, no stall.
